// File: rtl/aes_pkg.sv
// Shared AES decryption types, constants and GF(2^8) helpers.
// Used by inv_round_controller; the INV_ROUND_ABORT_EN build option lives there.
package aes_pkg;

   localparam int unsigned AES_NR  = 10;
   localparam int unsigned AES_BW  = 128;
   localparam int unsigned AES_RW  = 4;

   // 16 bytes, byte k at bits [127-8k -: 8]; row = k mod 4, column = k div 4
   typedef logic [3:0][3:0][7:0] aes_state_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } inv_fsm_e;

   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] gf_mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   function automatic logic [7:0] gf_mul4(input logic [7:0] a);
      return gf_mul2(gf_mul2(a));
   endfunction

   // Entry a sits at bit 2047-8a, which is {~a, 3'b111}
   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return INV_SBOX[{~a, 3'b111} -: 8];
   endfunction

endpackage

// File: rtl/inv_round_controller_if.sv
// Ciphertext-in / plaintext-out handshakes plus the round-key request port.
interface inv_round_controller_if;
   import aes_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [AES_BW-1:0]     in_data;
   logic [AES_RW-1:0]     key_idx;
   logic [AES_BW-1:0]     key_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [AES_BW-1:0]     out_data;
   logic                  busy;

   modport slave (
      input  in_valid, in_data, key_in, out_ready,
      output in_ready, key_idx, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_data, key_in, out_ready,
      input  in_ready, key_idx, out_valid, out_data, busy
   );
endinterface

// File: rtl/inv_round_datapath.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module inv_round_datapath
   import aes_pkg::*;
(
   input  aes_state_t         i_state,
   input  logic [AES_BW-1:0]  i_key,
   input  logic               i_last,
   output aes_state_t         o_state
);

   logic [AES_BW-1:0] w_in;
   logic [AES_BW-1:0] w_sub;
   logic [AES_BW-1:0] w_ark;
   logic [AES_BW-1:0] w_mix;

   assign w_in = i_state;

   // Row r rotates right by r: output column c takes input column (c - r) mod 4
   for (genvar c = 0; c < 4; c++) begin : g_c
      for (genvar r = 0; r < 4; r++) begin : g_r
         localparam int unsigned SRC = 4 * ((c + 4 - r) % 4) + r;
         assign w_sub[127-8*(4*c+r) -: 8] = inv_sbox(w_in[127-8*SRC -: 8]);
      end
   end

   assign w_ark = w_sub ^ i_key;

   reversediffusion u_mix (
      .i_data (w_ark),
      .o_data (w_mix)
   );

   assign o_state = i_last ? w_ark : w_mix;

endmodule

// File: rtl/reversediffusion.sv
// InvMixColumns on a 128-bit column-major block.
module reversediffusion
   import aes_pkg::*;
(
   input  logic [AES_BW-1:0] i_data,
   output logic [AES_BW-1:0] o_data
);

   // InvMixColumns = MixColumns after a 04/05 pre-multiply per column
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] w_a0, w_a1, w_a2, w_a3;
      logic [7:0] w_u, w_v, w_p0, w_p1, w_p2, w_p3, w_t;

      assign w_a0 = i_data[127-32*c -: 8];
      assign w_a1 = i_data[119-32*c -: 8];
      assign w_a2 = i_data[111-32*c -: 8];
      assign w_a3 = i_data[103-32*c -: 8];

      assign w_u  = gf_mul4(w_a0 ^ w_a2);
      assign w_v  = gf_mul4(w_a1 ^ w_a3);
      assign w_p0 = w_a0 ^ w_u;
      assign w_p1 = w_a1 ^ w_v;
      assign w_p2 = w_a2 ^ w_u;
      assign w_p3 = w_a3 ^ w_v;
      assign w_t  = w_p0 ^ w_p1 ^ w_p2 ^ w_p3;

      assign o_data[127-32*c -: 8] = w_p0 ^ w_t ^ gf_mul2(w_p0 ^ w_p1);
      assign o_data[119-32*c -: 8] = w_p1 ^ w_t ^ gf_mul2(w_p1 ^ w_p2);
      assign o_data[111-32*c -: 8] = w_p2 ^ w_t ^ gf_mul2(w_p2 ^ w_p3);
      assign o_data[103-32*c -: 8] = w_p3 ^ w_t ^ gf_mul2(w_p3 ^ w_p0);
   end

endmodule

// File: rtl/inv_round_controller.sv
// AES-128 decryption sequencer over one shared inverse-round datapath.
// Define INV_ROUND_ABORT_EN to add the abort input.
module inv_round_controller
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES_NR
)(
   input  logic                  clk,
   input  logic                  reset,
`ifdef INV_ROUND_ABORT_EN
   input  logic                  abort,
`endif
   inv_round_controller_if.slave bus
);

   inv_fsm_e           r_fsm;
   logic [AES_RW-1:0]  r_round;
   aes_state_t         r_state;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;

   aes_state_t         w_dp_state;
   logic               w_last;
   logic               w_abort;

   assign w_last = (r_fsm == ST_FINAL);

`ifdef INV_ROUND_ABORT_EN
   assign w_abort = abort & ((r_fsm == ST_INIT) | (r_fsm == ST_ROUND) | (r_fsm == ST_FINAL));
`else
   assign w_abort = 1'b0;
`endif

   inv_round_datapath u_dp (
      .i_state (r_state),
      .i_key   (bus.key_in),
      .i_last  (w_last),
      .o_state (w_dp_state)
   );

   // Sequencer; the state register is deliberately kept on abort
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm       <= ST_IDLE;
         r_round     <= '0;
         r_state     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (w_abort) begin
         r_fsm       <= ST_IDLE;
         r_round     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_state    <= bus.in_data;
                  r_round    <= AES_RW'(NR);
                  r_fsm      <= ST_INIT;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            ST_INIT: begin
               r_state <= r_state ^ bus.key_in;
               r_round <= r_round - AES_RW'(1);
               r_fsm   <= ST_ROUND;
            end
            ST_ROUND: begin
               r_state <= w_dp_state;
               r_round <= r_round - AES_RW'(1);
               if (r_round == AES_RW'(1)) begin
                  r_fsm <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               r_state     <= w_dp_state;
               r_fsm       <= ST_DONE;
               r_out_valid <= 1'b1;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_fsm       <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_fsm       <= ST_IDLE;
               r_round     <= '0;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.key_idx   = r_round;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_state;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_inv_round_controller.sv
// Directed bench for inv_round_controller using FIPS-197 C.1 and Appendix B vectors.
module tb_inv_round_controller;

   logic clk;
   logic reset;
`ifdef INV_ROUND_ABORT_EN
   logic abort;
`endif
   logic key_sel;

   logic [127:0] rk_a [0:10];
   logic [127:0] rk_b [0:10];

   localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int cyc_a   = 0;
   int cyc_b   = 0;

   inv_round_controller_if bus ();

   inv_round_controller #(.NR(10)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef INV_ROUND_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External key store: combinational lookup by requested index
   assign bus.key_in = (bus.key_idx > 4'd10) ? 128'h0 :
                       (key_sel ? rk_b[bus.key_idx] : rk_a[bus.key_idx]);

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_out(input string tag);
      for (int i = 0; i < 30 && !bus.out_valid; i++) tick();
      chk(tag, 128'(bus.out_valid), 128'(1));
   endtask

   task automatic wait_round(input logic [3:0] r, input string tag);
      for (int i = 0; i < 30 && !(bus.busy && bus.key_idx == r); i++) tick();
      chk(tag, 128'(bus.key_idx), 128'(r));
   endtask

   initial begin
      rk_a[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      rk_a[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      rk_a[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      rk_a[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      rk_a[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      rk_a[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      rk_a[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
      rk_a[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
      rk_a[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
      rk_a[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
      rk_a[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      rk_b[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk_b[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk_b[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk_b[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk_b[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk_b[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk_b[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk_b[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk_b[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk_b[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk_b[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      reset         = 1'b1;
      key_sel       = 1'b0;
`ifdef INV_ROUND_ABORT_EN
      abort         = 1'b0;
`endif
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_out_data",  bus.out_data,        128'h0);
      chk("rst_key_idx",   128'(bus.key_idx),   128'(0));
      chk("rst_busy",      128'(bus.busy),      128'(0));
      reset = 1'b0;
      tick();

      // C.1 block: key trace 10..0 and out_valid exactly 11 edges after acceptance
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i <= 10; i++) begin
         chk($sformatf("trace_key_%0d", i), 128'(bus.key_idx), 128'(10 - i));
         chk($sformatf("trace_nov_%0d", i), 128'(bus.out_valid), 128'(0));
         tick();
      end
      chk("c1_out_valid", 128'(bus.out_valid), 128'(1));
      chk("c1_out_data",  bus.out_data,        PT_A);
      chk("c1_busy",      128'(bus.busy),      128'(1));

      // Backpressure: DONE holds, a second block is refused
      bus.in_valid = 1'b1;
      bus.in_data  = CT_B;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("bp_valid_%0d", i), 128'(bus.out_valid), 128'(1));
         chk($sformatf("bp_data_%0d", i),  bus.out_data,        PT_A);
         chk($sformatf("bp_ready_%0d", i), 128'(bus.in_ready),  128'(0));
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_rel_valid", 128'(bus.out_valid), 128'(0));
      chk("bp_rel_ready", 128'(bus.in_ready),  128'(1));
      chk("bp_rel_busy",  128'(bus.busy),      128'(0));
      chk("bp_rel_data",  bus.out_data,        PT_A);

      // Back-to-back: A then B; accepts are INIT+9 ROUND+FINAL+DONE+IDLE = 13 edges apart
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      cyc_a = cyc;
      bus.in_data = CT_B;
      wait_out("b2b_a_valid");
      chk("b2b_a_data", bus.out_data, PT_A);
      key_sel = 1'b1;
      tick();
      wait_round(4'd10, "b2b_b_start");
      cyc_b = cyc;
      bus.in_valid = 1'b0;
      chk("b2b_spacing", 128'(cyc_b - cyc_a), 128'(13));
      wait_out("b2b_b_valid");
      chk("b2b_b_data", bus.out_data, PT_B);
      tick();
      key_sel = 1'b0;

      // Reset mid-operation at round 5, then a fresh block
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      bus.in_valid = 1'b0;
      wait_round(4'd5, "mid_round5");
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_busy",      128'(bus.busy),      128'(0));
      chk("mid_out_valid", 128'(bus.out_valid), 128'(0));
      chk("mid_in_ready",  128'(bus.in_ready),  128'(1));
      chk("mid_key_idx",   128'(bus.key_idx),   128'(0));
      chk("mid_out_data",  bus.out_data,        128'h0);
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      bus.in_valid = 1'b0;
      wait_out("mid_fresh_valid");
      chk("mid_fresh_data", bus.out_data, PT_A);
      tick();

`ifdef INV_ROUND_ABORT_EN
      // Abort at round 3 drops the block; the next one still decrypts
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      bus.in_valid = 1'b0;
      wait_round(4'd3, "ab_round3");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_busy",     128'(bus.busy),     128'(0));
      chk("ab_in_ready", 128'(bus.in_ready), 128'(1));
      chk("ab_key_idx",  128'(bus.key_idx),  128'(0));
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("ab_nov_%0d", i), 128'(bus.out_valid), 128'(0));
         tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = CT_A;
      tick();
      bus.in_valid = 1'b0;
      wait_out("ab_next_valid");
      chk("ab_next_data", bus.out_data, PT_A);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
